// File: rtl/tdc_pkg.sv
// Shared definitions for carry-chain TDC channel blocks: FSM states and tap/code width helpers.
package tdc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        CAPTURE,
        OUTPUT,
        DEAD
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic int taps_of(input int ncarry4);
        return 4 * ncarry4;
    endfunction

    // Fine code must represent 0..TAPS inclusive, so one more value than there are taps.
    function automatic int fine_w_of(input int ncarry4);
        return clog2(4 * ncarry4 + 1);
    endfunction

endpackage

// File: rtl/tdc_hit_capture_ctrl_if.sv
// Timestamp valid/ready stream from a TDC channel to its readout FIFO.
interface tdc_hit_capture_ctrl_if #(
    parameter int DATA_W = 25
);
    logic              ts_valid;
    logic              ts_ready;
    logic [DATA_W-1:0] ts_data;

    modport master (output ts_valid, output ts_data, input ts_ready);
    modport slave  (input ts_valid, input ts_data, output ts_ready);
endinterface

// File: rtl/tdc_therm_popcount.sv
// Bubble-tolerant thermometer decoder: counts ones across the whole tap snapshot, one register stage.
module tdc_therm_popcount
    import tdc_pkg::*;
#(
    parameter int TAPS = 340
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [TAPS-1:0]            therm,
    output logic [clog2(TAPS+1)-1:0]   count
);

    localparam int CNT_W = clog2(TAPS + 1);

    logic [CNT_W-1:0] sum;

    // NOTE: combinational logic uses blocking '=' with a default assigned first, so no latch is inferred.
    always_comb begin
        sum = '0;
        for (int i = 0; i < TAPS; i++) begin
            sum = sum + CNT_W'(therm[i]);
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= sum;
        end
    end

endmodule

// File: rtl/tdc_hit_capture_ctrl.sv
// One carry-chain TDC channel: hit detect, coarse latch, fine encode, timestamp stream, dead time.
// Optional hit-drop counter enabled by defining TDC_DROP_CNT_EN.
module tdc_hit_capture_ctrl
    import tdc_pkg::*;
#(
    parameter int NCARRY4     = 85,
    parameter int COARSE_W    = 16,
    parameter int DEAD_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [4*NCARRY4-1:0]        taps_in,
    tdc_hit_capture_ctrl_if.master      ts,
    output logic                        armed,
    output logic [15:0]                 drop_cnt
);

    localparam int TAPS   = taps_of(NCARRY4);
    localparam int FINE_W = fine_w_of(NCARRY4);
    localparam int DEAD_W = clog2(DEAD_CYCLES + 1);

    state_t state;
    state_t state_next;

    logic [TAPS-1:0]     s1;
    logic [TAPS-1:0]     s2;
    logic                s2d0;
    logic [TAPS-1:0]     snapshot;
    logic [COARSE_W-1:0] coarse;
    logic [COARSE_W-1:0] coarse_lat;
    logic [FINE_W-1:0]   fine;
    logic [DEAD_W-1:0]   dead_cnt;
    logic                hit;
    logic                chain_clear;
    logic                dead_done;

    // taps_in is asynchronous to clk: two plain flops before anything looks at it.
    // NOTE: every register here, including the wide sample and snapshot flops, is reset so that
    // a mid-operation reset leaves no stale edge or timestamp behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            s2d0 <= 1'b0;
        end else begin
            s1   <= taps_in;
            s2   <= s1;
            s2d0 <= s2[0];
        end
    end

    assign hit         = s2[0] & ~s2d0;
    assign chain_clear = (s2 == '0);
    assign dead_done   = (dead_cnt == DEAD_W'(DEAD_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coarse <= '0;
        end else begin
            coarse <= coarse + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = ARMED;
            ARMED: begin
                if (!enable)  state_next = IDLE;
                else if (hit) state_next = CAPTURE;
            end
            CAPTURE: state_next = OUTPUT;
            OUTPUT:  if (ts.ts_ready) state_next = DEAD;
            DEAD: begin
                // Hold off until the minimum dead time has elapsed and the line has fully drained.
                if (dead_done && chain_clear) state_next = enable ? ARMED : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coarse_lat <= '0;
            snapshot   <= '0;
        end else if (state == ARMED && enable && hit) begin
            coarse_lat <= coarse;
            snapshot   <= s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dead_cnt <= '0;
        end else if (state != DEAD) begin
            dead_cnt <= '0;
        end else if (!dead_done) begin
            dead_cnt <= dead_cnt + 1'b1;
        end
    end

    tdc_therm_popcount #(
        .TAPS (TAPS)
    ) u_popcount (
        .clk   (clk),
        .rst   (rst),
        .load  (state == CAPTURE),
        .therm (snapshot),
        .count (fine)
    );

    // Outputs decode straight from the state register so an async reset clears them at once.
    assign ts.ts_valid = (state == OUTPUT);
    assign ts.ts_data  = (state == OUTPUT) ? {coarse_lat, fine} : '0;
    assign armed       = (state == ARMED);

`ifdef TDC_DROP_CNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else if (hit && enable && state != ARMED && drop_q != 16'hFFFF) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

endmodule
